// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants for the FP32 CORDIC rotator.
// The K-compensation constants exist only with CORDIC_GAIN_COMP_EN.
package cordic_pkg;

   localparam int ITER_MAX = 24;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROT,
      ST_COMP,
      ST_DONE
   } state_t;

   // atan(2^-i) in FP32, i = 0..23
   localparam logic [31:0] ATAN_TABLE [ITER_MAX] = '{
      32'h3F490FDB, 32'h3EED6338, 32'h3E7ADBB0, 32'h3DFEADD5,
      32'h3D7FAADE, 32'h3CFFEAAE, 32'h3C7FFAAB, 32'h3BFFFEAB,
      32'h3B7FFFAB, 32'h3AFFFFEB, 32'h3A7FFFFB, 32'h39FFFFFF,
      32'h39800000, 32'h39000000, 32'h38800000, 32'h38000000,
      32'h37800000, 32'h37000000, 32'h36800000, 32'h36000000,
      32'h35800000, 32'h35000000, 32'h34800000, 32'h34000000
   };

`ifdef CORDIC_GAIN_COMP_EN
   // K = 2^-1 + 2^-3 - 2^-6 - 2^-9; KSUB bit set = subtract term
   localparam logic [4:0] KSHIFT [4] = '{5'd1, 5'd3, 5'd6, 5'd9};
   localparam logic [3:0] KSUB = 4'b1100;
`endif

   // FP32 * 2^-k by exponent decrement; exponent <= k flushes to +0
   function automatic logic [31:0] fp_pow2_dec(
      input logic [31:0] a,
      input logic [4:0]  k
   );
      if (a[30:23] <= {3'b000, k})
         return 32'h0000_0000;
      return {a[31], a[30:23] - {3'b000, k}, a[22:0]};
   endfunction

endpackage

// File: rtl/fp_scale_pow2.sv
// fp_scale_pow2: FP32 times 2^-k via exponent decrement.
// Flushes to +0 when the exponent would reach zero; flags zero.
module fp_scale_pow2
   import cordic_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [4:0]  i_k,
   output logic [31:0] o_r,
   output logic        o_zero
);

   assign o_r    = fp_pow2_dec(i_a, i_k);
   assign o_zero = (o_r[30:23] == 8'd0);

endmodule

// File: rtl/fpu_add_sub.sv
// fpu_add_sub: combinational FP32 add/subtract, truncating rounding.
// Zero results and exponent underflow give +0; no NaN/Inf handling.
module fpu_add_sub (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_control,
   output logic [31:0] o_result
);

   logic        sb, swap, s_l, s_s, found;
   logic [7:0]  e_l, e_s, de;
   logic [23:0] m_l, m_s;
   logic [26:0] al, nrm;
   logic [27:0] sum;
   logic [4:0]  lz;
   logic [9:0]  e_n;
   logic        unused_bits;

   // align smaller operand, add magnitudes, normalise, truncate
   always_comb begin
      sb   = i_b[31] ^ i_control;
      swap = i_b[30:0] > i_a[30:0];
      s_l  = swap ? sb : i_a[31];
      s_s  = swap ? i_a[31] : sb;
      e_l  = swap ? i_b[30:23] : i_a[30:23];
      e_s  = swap ? i_a[30:23] : i_b[30:23];
      m_l  = {1'b1, swap ? i_b[22:0] : i_a[22:0]};
      m_s  = {1'b1, swap ? i_a[22:0] : i_b[22:0]};
      de   = e_l - e_s;
      al   = (de > 8'd26) ? 27'd0 : ({m_s, 3'b000} >> de);
      if (s_l == s_s)
         sum = {1'b0, m_l, 3'b000} + {1'b0, al};
      else
         sum = {1'b0, m_l, 3'b000} - {1'b0, al};
      lz    = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!found && sum[i]) begin
            lz    = 5'(26 - i);
            found = 1'b1;
         end
      end
      if (sum[27]) begin
         nrm = sum[27:1];
         e_n = {2'b00, e_l} + 10'd1;
      end else begin
         nrm = sum[26:0] << lz;
         e_n = {2'b00, e_l} - {5'b00000, lz};
      end
      if (sum == 28'd0 || e_n == 10'd0 || e_n[9])
         o_result = 32'h0000_0000;
      else
         o_result = {s_l, e_n[7:0], nrm[25:3]};
   end

   assign unused_bits = ^{nrm[26], nrm[2:0], e_n[8]};

endmodule

// File: rtl/cordic_fp_rotator.sv
// cordic_fp_rotator: iterative FP32 CORDIC rotator, one step per clock.
// CORDIC_GAIN_COMP_EN adds a 3-cycle COMP state scaling by K.
module cordic_fp_rotator
   import cordic_pkg::*;
#(
   parameter int ITER = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_x,
   input  logic [31:0] i_y,
   input  logic [31:0] i_z,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_x,
   output logic [31:0] o_y
);

   localparam logic [4:0] K_LAST = 5'(ITER - 1);

   state_t      state_q;
   logic [31:0] x_q, y_q, z_q;
   logic [31:0] ox_q, oy_q;
   logic [4:0]  k_q;
   logic        valid_q;
`ifdef CORDIC_GAIN_COMP_EN
   logic [1:0]  c_q;
   logic [31:0] acx_q, acy_q;
`endif

   logic        d;
   logic [4:0]  sh;
   logic [31:0] sx_in, sy_in, sx, sy;
   logic        sx_zero, sy_zero;
   logic [31:0] ax, ay;
   logic        opx, opy;
   logic [31:0] addx, addy, addz;
   logic [31:0] x_d, y_d, z_d;

   // zero operands skip the adder: a +/- 0 = a, 0 +/- b = +/-b
   function automatic logic [31:0] pick(
      input logic [31:0] a,
      input logic [31:0] b,
      input logic        b_zero,
      input logic        sub,
      input logic [31:0] sum
   );
      if (b_zero)
         return a;
      if (a[30:23] == 8'd0)
         return {b[31] ^ sub, b[30:0]};
      return sum;
   endfunction

   assign d       = ~z_q[31];
   assign o_ready = (state_q == ST_IDLE);
   assign o_valid = valid_q;
   assign o_x     = ox_q;
   assign o_y     = oy_q;

   // operand steering: micro-rotation in ROT, K-scaling in COMP
   always_comb begin
      sh    = k_q;
      sx_in = y_q;
      sy_in = x_q;
      ax    = x_q;
      ay    = y_q;
      opx   = d;
      opy   = ~d;
`ifdef CORDIC_GAIN_COMP_EN
      if (state_q == ST_COMP) begin
         sh    = KSHIFT[c_q + 2'd1];
         sx_in = x_q;
         sy_in = y_q;
         ax    = (c_q == 2'd0) ? fp_pow2_dec(x_q, KSHIFT[0]) : acx_q;
         ay    = (c_q == 2'd0) ? fp_pow2_dec(y_q, KSHIFT[0]) : acy_q;
         opx   = KSUB[c_q + 2'd1];
         opy   = KSUB[c_q + 2'd1];
      end
`endif
   end

   fp_scale_pow2 u_scl_x (
      .i_a(sx_in), .i_k(sh), .o_r(sx), .o_zero(sx_zero)
   );
   fp_scale_pow2 u_scl_y (
      .i_a(sy_in), .i_k(sh), .o_r(sy), .o_zero(sy_zero)
   );

   fpu_add_sub u_add_x (
      .i_a(ax), .i_b(sx), .i_control(opx), .o_result(addx)
   );
   fpu_add_sub u_add_y (
      .i_a(ay), .i_b(sy), .i_control(opy), .o_result(addy)
   );
   fpu_add_sub u_add_z (
      .i_a(z_q), .i_b(ATAN_TABLE[k_q]),
      .i_control(d), .o_result(addz)
   );

   assign x_d = pick(ax, sx, sx_zero, opx, addx);
   assign y_d = pick(ay, sy, sy_zero, opy, addy);
   assign z_d = pick(z_q, ATAN_TABLE[k_q], 1'b0, d, addz);

   // control FSM with registered result and valid
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         ox_q    <= 32'h0;
         oy_q    <= 32'h0;
         k_q     <= 5'd0;
`ifdef CORDIC_GAIN_COMP_EN
         c_q     <= 2'd0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  x_q     <= i_x;
                  y_q     <= i_y;
                  z_q     <= i_z;
                  k_q     <= 5'd0;
                  state_q <= ST_ROT;
               end
            end
            ST_ROT: begin
               x_q <= x_d;
               y_q <= y_d;
               z_q <= z_d;
               if (k_q == K_LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
                  c_q     <= 2'd0;
                  state_q <= ST_COMP;
`else
                  ox_q    <= x_d;
                  oy_q    <= y_d;
                  valid_q <= 1'b1;
                  state_q <= ST_DONE;
`endif
               end else begin
                  k_q <= k_q + 5'd1;
               end
            end
`ifdef CORDIC_GAIN_COMP_EN
            ST_COMP: begin
               acx_q <= x_d;
               acy_q <= y_d;
               c_q   <= c_q + 2'd1;
               if (c_q == 2'd2) begin
                  ox_q    <= x_d;
                  oy_q    <= y_d;
                  valid_q <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
`endif
            ST_DONE: begin
               if (i_ready) begin
                  valid_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_fp_rotator.sv
// tb_cordic_fp_rotator: directed vectors plus handshake,
// mid-rotation reset and back-to-back sequences.
module tb_cordic_fp_rotator;

   localparam int ITER = 16;
`ifdef CORDIC_GAIN_COMP_EN
   localparam real GAIN = 1.0002782;
   localparam int  LAT  = ITER + 3;
`else
   localparam real GAIN = 1.6467602578;
   localparam int  LAT  = ITER;
`endif
   localparam int GAP = LAT + 2;

   logic        clk, rst;
   logic        i_valid, o_ready, o_valid, i_ready;
   logic [31:0] i_x, i_y, i_z, o_x, o_y;

   int checks = 0;
   int fails  = 0;

   cordic_fp_rotator #(.ITER(ITER)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_x(i_x), .i_y(i_y), .i_z(i_z),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_x(o_x), .o_y(o_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // expected values are true rotation * 1e6, scaled by GAIN
   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
      int          ex;
      int          ey;
      logic        exact;
   } vec_t;

   vec_t tv [7];

   function automatic real rabs(input real v);
      return (v < 0.0) ? -v : v;
   endfunction

   function automatic real fp2r(input logic [31:0] b);
      real m;
      int  e, f;
      e = int'(b[30:23]);
      f = int'(b[22:0]);
      if (e == 0) return 0.0;
      m = 1.0 + f / 8388608.0;
      while (e > 127) begin m = m * 2.0; e--; end
      while (e < 127) begin m = m / 2.0; e++; end
      return b[31] ? -m : m;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bits(input string nm,
                           input logic [31:0] act,
                           input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_real(input string nm,
                           input logic [31:0] act,
                           input int exp_u);
      real a, e, tol;
      a   = fp2r(act);
      e   = exp_u / 1.0e6 * GAIN;
      tol = 1.0e-3 * ((rabs(e) > 1.0) ? rabs(e) : 1.0);
      checks++;
      if (rabs(a - e) > tol) begin
         fails++;
         $display("FAIL %s: got %f want %f", nm, a, e);
      end
   endtask

   task automatic chk_vec(input string nm, input int i,
                          input logic [31:0] rx,
                          input logic [31:0] ry);
      if (tv[i].exact) begin
         chk_bits({nm, "_x"}, rx, 32'h0);
         chk_bits({nm, "_y"}, ry, 32'h0);
      end else begin
         chk_real({nm, "_x"}, rx, tv[i].ex);
         chk_real({nm, "_y"}, ry, tv[i].ey);
      end
   endtask

   task automatic drive(input int i);
      i_x = tv[i].x;
      i_y = tv[i].y;
      i_z = tv[i].z;
   endtask

   // accept one vector, wait for o_valid, handshake it
   task automatic run(input int i, output logic [31:0] rx,
                      output logic [31:0] ry, output int lat);
      int n;
      drive(i);
      i_ready = 1'b0;
      i_valid = 1'b1;
      n = 0;
      while (!o_ready && n < 50) begin step(); n++; end
      step();
      i_valid = 1'b0;
      lat = 0;
      while (!o_valid && lat < 300) begin step(); lat++; end
      if (!o_valid) begin
         fails++;
         $display("FAIL timeout vec%0d: o_valid never rose", i);
      end
      rx = o_x;
      ry = o_y;
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] rx, ry, hx, hy;
      logic [31:0] bx [2];
      logic [31:0] by [2];
      int          tacc [2];
      int          lat, nacc, nres, cyc;
      logic        acc_now;

      tv[0] = '{32'h3F800000, 32'h00000000, 32'h3F060A92,
                866025, 500000, 1'b0};
      tv[1] = '{32'h3F800000, 32'h00000000, 32'hBF490FDB,
                707107, -707107, 1'b0};
      tv[2] = '{32'h00000000, 32'h00000000, 32'h3F800000,
                0, 0, 1'b1};
      tv[3] = '{32'h00000000, 32'h3F800000, 32'h3F000000,
                -479426, 877583, 1'b0};
      tv[4] = '{32'h40000000, 32'h00000000, 32'h00000000,
                2000000, 0, 1'b0};
      tv[5] = '{32'h3F800000, 32'h3F800000, 32'hBF000000,
                1357008, 398157, 1'b0};
      tv[6] = '{32'h3F800000, 32'h00000000, 32'h3FC90FDB,
                0, 1000000, 1'b0};

      rst = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_x = 32'h0;
      i_y = 32'h0;
      i_z = 32'h0;
      repeat (3) step();
      rst = 1'b0;
      chk_bits("rst_valid", {31'b0, o_valid}, 32'h0);
      chk_bits("rst_ready", {31'b0, o_ready}, 32'h1);
      chk_bits("rst_ox", o_x, 32'h0);
      chk_bits("rst_oy", o_y, 32'h0);

      for (int i = 0; i < 7; i++) begin
         run(i, rx, ry, lat);
         chk_int($sformatf("lat%0d", i), lat, LAT);
         chk_vec($sformatf("vec%0d", i), i, rx, ry);
         checks++;
         if (rabs(fp2r(dut.z_q)) >= 6.103515625e-5) begin
            fails++;
            $display("FAIL zconv%0d: got %f want <6.1e-5",
                     i, fp2r(dut.z_q));
         end
         chk_bits($sformatf("idle_ready%0d", i),
                  {31'b0, o_ready}, 32'h1);
      end

      // stall downstream 5 cycles; stray i_valid must be ignored
      drive(0);
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      cyc = 0;
      while (!o_valid && cyc < 300) begin step(); cyc++; end
      hx = o_x;
      hy = o_y;
      chk_vec("hold", 0, hx, hy);
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin drive(3); i_valid = 1'b1; end
         step();
         i_valid = 1'b0;
         chk_bits($sformatf("hold_x%0d", c), o_x, hx);
         chk_bits($sformatf("hold_y%0d", c), o_y, hy);
         chk_bits($sformatf("hold_ready%0d", c),
                  {31'b0, o_ready}, 32'h0);
         chk_bits($sformatf("hold_valid%0d", c),
                  {31'b0, o_valid}, 32'h1);
      end
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
      chk_bits("post_hs_valid", {31'b0, o_valid}, 32'h0);
      repeat (3) step();
      chk_bits("stray_ignored_valid", {31'b0, o_valid}, 32'h0);
      chk_bits("stray_ignored_ready", {31'b0, o_ready}, 32'h1);

      // reset while rotating at k=7, then a clean transaction
      drive(5);
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      repeat (7) step();
      chk_bits("k_at_rst", {27'b0, dut.k_q}, 32'd7);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_bits("midrst_valid", {31'b0, o_valid}, 32'h0);
      chk_bits("midrst_ready", {31'b0, o_ready}, 32'h1);
      chk_bits("midrst_ox", o_x, 32'h0);
      chk_bits("midrst_oy", o_y, 32'h0);
      run(3, rx, ry, lat);
      chk_int("after_rst_lat", lat, LAT);
      chk_vec("after_rst", 3, rx, ry);

      // back-to-back with i_ready held high
      i_ready = 1'b1;
      drive(0);
      i_valid = 1'b1;
      nacc = 0;
      nres = 0;
      cyc = 0;
      while (nres < 2 && cyc < 400) begin
         acc_now = i_valid && o_ready;
         if (o_valid) begin
            bx[nres] = o_x;
            by[nres] = o_y;
            nres++;
         end
         if (acc_now) begin
            tacc[nacc] = cyc;
            nacc++;
         end
         step();
         cyc++;
         if (acc_now) begin
            if (nacc == 1) drive(3);
            else i_valid = 1'b0;
         end
      end
      i_valid = 1'b0;
      i_ready = 1'b0;
      if (nres < 2 || nacc < 2) begin
         fails++;
         $display("FAIL b2b_timeout: results %0d accepts %0d want 2",
                  nres, nacc);
      end else begin
         chk_int("b2b_interval", tacc[1] - tacc[0], GAP);
         chk_vec("b2b_first", 0, bx[0], by[0]);
         chk_vec("b2b_second", 3, bx[1], by[1]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
